// File: rtl/ttl_74161_if.sv
// rtl/ttl_74161_if.sv - load/enable/data/count bundle for the presettable counter
interface ttl_74161_if #(
   parameter int WIDTH = 4
);
   logic             Load_bar;
   logic             ENP;
   logic             ENT;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic             RCO;

   modport master (
      output Load_bar,
      output ENP,
      output ENT,
      output D,
      input  Q,
      input  RCO
   );

   modport slave (
      input  Load_bar,
      input  ENP,
      input  ENT,
      input  D,
      output Q,
      output RCO
   );
endinterface

// File: rtl/ttl_74161.sv
// rtl/ttl_74161.sv - presettable synchronous binary counter with async clear and ripple carry
module ttl_74161 #(
   parameter int WIDTH      = 4,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic        Clk,
   input  logic        Clear_bar,
   ttl_74161_if.slave  bus
);
   logic [WIDTH-1:0] count;
   logic             carry;

   // Load beats counting; ENP and ENT must both be high to advance.
   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         count <= '0;
      end else if (!bus.Load_bar) begin
         count <= bus.D;
      end else if (bus.ENP && bus.ENT) begin
         count <= count + WIDTH'(1);
      end
   end

   // ENT alone gates the carry so a cascade stage only sees carry from the stage below.
   assign carry = bus.ENT && (count == {WIDTH{1'b1}});

   generate
      if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_no_delay
         assign bus.Q   = count;
         assign bus.RCO = carry;
      end else begin : g_delay
         assign #(DELAY_RISE, DELAY_FALL) bus.Q   = count;
         assign #(DELAY_RISE, DELAY_FALL) bus.RCO = carry;
      end
   endgenerate
endmodule

// File: tb/tb_ttl_74161.sv
// tb/tb_ttl_74161.sv - scoreboard bench for the counter, a 3-stage cascade and a decoder pairing
module tb_ttl_74161;
   typedef struct {
      string       name;
      bit          casc;
      logic [11:0] val;
      logic        rco;
   } exp_t;

   logic Clk       = 1'b0;
   logic Clear_bar = 1'b0;
   always #5 Clk = ~Clk;

   ttl_74161_if #(.WIDTH(4)) m_if ();
   ttl_74161_if #(.WIDTH(4)) c0_if ();
   ttl_74161_if #(.WIDTH(4)) c1_if ();
   ttl_74161_if #(.WIDTH(4)) c2_if ();

   ttl_74161 #(.WIDTH(4)) dut  (.Clk(Clk), .Clear_bar(Clear_bar), .bus(m_if));
   ttl_74161 #(.WIDTH(4)) u_c0 (.Clk(Clk), .Clear_bar(Clear_bar), .bus(c0_if));
   ttl_74161 #(.WIDTH(4)) u_c1 (.Clk(Clk), .Clear_bar(Clear_bar), .bus(c1_if));
   ttl_74161 #(.WIDTH(4)) u_c2 (.Clk(Clk), .Clear_bar(Clear_bar), .bus(c2_if));

   logic        c_load;
   logic        c_enp;
   logic        c_ent;
   logic [11:0] c_d;
   logic [15:0] dec_y;

   assign c0_if.Load_bar = c_load;
   assign c1_if.Load_bar = c_load;
   assign c2_if.Load_bar = c_load;
   assign c0_if.ENP      = c_enp;
   assign c1_if.ENP      = c_enp;
   assign c2_if.ENP      = c_enp;
   assign c0_if.ENT      = c_ent;
   assign c1_if.ENT      = c0_if.RCO;
   assign c2_if.ENT      = c1_if.RCO;
   assign c0_if.D        = c_d[3:0];
   assign c1_if.D        = c_d[7:4];
   assign c2_if.D        = c_d[11:8];

   // 4-to-16 decoder fed by the low stage, both enables held low: one active-low output
   assign dec_y = ~(16'h0001 << c0_if.Q);

   exp_t sb[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;
   event kick;

   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp_v);
      end
   endtask

   always @(negedge Clk or kick) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (!e.casc) begin
            chk({e.name, ".Q"}, {12'h0, m_if.Q}, {12'h0, e.val[3:0]});
            chk({e.name, ".RCO"}, {15'h0, m_if.RCO}, {15'h0, e.rco});
         end else begin
            chk({e.name, ".cnt"}, {4'h0, c2_if.Q, c1_if.Q, c0_if.Q}, {4'h0, e.val});
            chk({e.name, ".dec"}, dec_y, ~(16'h0001 << e.val[3:0]));
         end
      end
   end

   task automatic drive(input logic lb, input logic enp, input logic ent, input logic [3:0] d);
      m_if.Load_bar = lb;
      m_if.ENP      = enp;
      m_if.ENT      = ent;
      m_if.D        = d;
   endtask

   // One rising edge, queue the expectation, return just after the monitor's sample point.
   task automatic tick(input string n, input bit casc, input logic [11:0] v, input logic r);
      @(posedge Clk);
      #1;
      sb.push_back('{n, casc, v, r});
      @(negedge Clk);
      #1;
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 4'h0);
      c_load = 1'b1;
      c_enp  = 1'b0;
      c_ent  = 1'b0;
      c_d    = 12'h000;
      tick("reset", 1'b0, 12'h0, 1'b0);

      Clear_bar = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'h7);
      tick("load7", 1'b0, 12'h7, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 4'h0);
      tick("cnt8", 1'b0, 12'h8, 1'b0);
      tick("cnt9", 1'b0, 12'h9, 1'b0);

      // Clear lands between edges; checked before any rising edge occurs
      Clear_bar = 1'b0;
      sb.push_back('{"clr_async", 1'b0, 12'h0, 1'b0});
      #1 -> kick;
      tick("clr_hold", 1'b0, 12'h0, 1'b0);
      Clear_bar = 1'b1;
      tick("rel1", 1'b0, 12'h1, 1'b0);
      tick("rel2", 1'b0, 12'h2, 1'b0);
      tick("rel3", 1'b0, 12'h3, 1'b0);

      drive(1'b0, 1'b0, 1'b1, 4'hD);
      tick("loadD", 1'b0, 12'hD, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 4'h0);
      tick("wrapE", 1'b0, 12'hE, 1'b0);
      tick("wrapF", 1'b0, 12'hF, 1'b1);
      tick("wrap0", 1'b0, 12'h0, 1'b0);
      tick("wrap1", 1'b0, 12'h1, 1'b0);

      drive(1'b0, 1'b0, 1'b1, 4'hF);
      tick("loadF_ent", 1'b0, 12'hF, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 4'h0);
      tick("holdF_a", 1'b0, 12'hF, 1'b0);
      tick("holdF_b", 1'b0, 12'hF, 1'b0);

      drive(1'b0, 1'b0, 1'b0, 4'h5);
      tick("load5", 1'b0, 12'h5, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 4'h0);
      tick("en01", 1'b0, 12'h5, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 4'h0);
      tick("en10", 1'b0, 12'h5, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'h0);
      tick("en00", 1'b0, 12'h5, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 4'h0);
      tick("en11", 1'b0, 12'h6, 1'b0);

      drive(1'b0, 1'b1, 1'b1, 4'h3);
      tick("load_prio", 1'b0, 12'h3, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'hA);
      tick("loadA", 1'b0, 12'hA, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'h0);

      c_load = 1'b0;
      c_d    = 12'h0FF;
      tick("casc_load", 1'b1, 12'h0FF, 1'b0);
      c_load = 1'b1;
      c_enp  = 1'b1;
      c_ent  = 1'b1;
      tick("casc_carry", 1'b1, 12'h100, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         tick($sformatf("walk%0d", i), 1'b1, 12'h100 + 12'(i), 1'b0);
      end

      for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge Clk);
      #1;
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
